// File: rtl/bcd_to_binary.sv
// Iterative 3-digit BCD to 8-bit binary converter (reverse double-dabble, one bit per clock).
// Start/done handshake; inputs above 255 or with non-decimal digits are flagged through err.
module bcd_to_binary (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] hunds,
  input  logic [3:0] tens,
  input  logic [3:0] units,
  output logic       busy,
  output logic       done,
  output logic [7:0] bin,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t     state_q, state_d;
  logic [9:0] bcd_q, bcd_d;
  logic [7:0] binsr_q, binsr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] bin_q, bin_d;
  logic       err_q, err_d;

  logic [7:0] tens_x10;
  logic       invalid;
  logic [9:0] sh_bcd;
  logic [7:0] sh_bin;

  // Digit range and the >255 check are made on the raw inputs, not the captured copy.
  always_comb begin
    tens_x10 = {1'b0, tens, 3'b000} + {3'b000, tens, 1'b0};
    invalid  = (tens > 4'd9) || (units > 4'd9) || (hunds == 2'd3) ||
               ((hunds == 2'd2) && ((tens_x10 + {4'd0, units}) > 8'd55));
  end

  // One reverse double-dabble step: shift right, then undo the dabble on units and tens.
  always_comb begin
    sh_bcd = {1'b0, bcd_q[9:1]};
    sh_bin = {bcd_q[0], binsr_q[7:1]};
    if (sh_bcd[3:0] >= 4'd8) sh_bcd[3:0] = sh_bcd[3:0] - 4'd3;
    if (sh_bcd[7:4] >= 4'd8) sh_bcd[7:4] = sh_bcd[7:4] - 4'd3;
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    binsr_d = binsr_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d   = {hunds, tens, units};
          binsr_d = 8'h00;
          cnt_d   = 3'd0;
          if (invalid) begin
            state_d = DONE;
            bin_d   = 8'h00;
            err_d   = 1'b1;
          end else begin
            state_d = CONV;
          end
        end
      end
      CONV: begin
        bcd_d   = sh_bcd;
        binsr_d = sh_bin;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
          bin_d   = sh_bin;
          err_d   = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcd_q   <= 10'd0;
      binsr_q <= 8'd0;
      cnt_q   <= 3'd0;
      bin_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      binsr_q <= binsr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign bin  = bin_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: directed cases, handshake corner cases,
// exhaustive 0-255 sweep and random digit patterns against an arithmetic reference.
module tb_bcd_to_binary;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] hunds;
  logic [3:0] tens;
  logic [3:0] units;
  logic       busy;
  logic       done;
  logic [7:0] bin;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_to_binary dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .hunds (hunds),
    .tens  (tens),
    .units (units),
    .busy  (busy),
    .done  (done),
    .bin   (bin),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: digits are invalid if non-decimal or the decimal value exceeds 255.
  function automatic bit ref_invalid(input int h, input int t, input int u);
    return (t > 9) || (u > 9) || (100 * h + 10 * t + u > 255);
  endfunction

  function automatic int ref_bin(input int h, input int t, input int u);
    return ref_invalid(h, t, u) ? 0 : 100 * h + 10 * t + u;
  endfunction

  // Runs one conversion from IDLE and checks latency, result, error flag and pulse width.
  task automatic do_conv(input int h, input int t, input int u);
    int k;
    int lat;
    lat = ref_invalid(h, t, u) ? 1 : 9;
    @(negedge clk);
    hunds = 2'(h); tens = 4'(t); units = 4'(u);
    start = 1'b1;
    @(posedge clk);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("busy_after_accept", busy, 1);
        start = 1'b0;
        hunds = 2'($urandom); tens = 4'($urandom); units = 4'($urandom);
      end
      if (done) begin
        k = i;
        break;
      end
    end
    check("latency", k, lat);
    check("bin", bin, ref_bin(h, t, u));
    check("err", err, ref_invalid(h, t, u));
    @(negedge clk);
    check("done_width", done, 0);
    check("busy_released", busy, 0);
  endtask

  initial begin
    int t0, h, t, u, cnt, tprev;
    rst_n = 1'b0; start = 1'b1; hunds = 2'd1; tens = 4'd2; units = 4'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bin", bin, 0);
    check("rst_err", err, 0);
    start = 1'b0;
    rst_n = 1'b1;

    // Directed values and invalid patterns.
    do_conv(0, 0, 0);
    do_conv(1, 2, 5);
    do_conv(0, 5, 6);
    do_conv(2, 5, 5);
    do_conv(2, 5, 6);
    do_conv(0, 10, 0);
    do_conv(3, 0, 0);
    do_conv(0, 0, 15);

    // start pulsed while busy must not launch a second conversion.
    @(negedge clk);
    hunds = 2'd0; tens = 4'd5; units = 4'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    hunds = 2'd0; tens = 4'd0; units = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) begin
        cnt++;
        check("busy_start_bin", bin, ref_bin(0, 5, 6));
      end
      @(negedge clk);
    end
    check("busy_start_done_count", cnt, 1);
    check("busy_start_idle", busy, 0);

    // start held high: a result every 10 cycles.
    @(negedge clk);
    hunds = 2'd1; tens = 4'd0; units = 4'd0; start = 1'b1;
    cnt = 0; tprev = -1;
    for (int i = 0; i < 40 && cnt < 3; i++) begin
      @(negedge clk);
      if (done) begin
        check("hold_bin", bin, ref_bin(1, 0, 0));
        if (tprev >= 0) check("hold_period", i - tprev, 10);
        tprev = i;
        cnt++;
      end
    end
    start = 1'b0;
    check("hold_done_count", cnt, 3);
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    check("hold_idle", busy, 0);

    // Reset at iteration 4 aborts with no done.
    hunds = 2'd1; tens = 4'd2; units = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      check("abort_no_done_pre", done, 0);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_bin", bin, 0);
    check("abort_err", err, 0);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("abort_no_done_post", cnt, 0);
    do_conv(0, 0, 3);

    // Exhaustive valid sweep.
    for (int v = 0; v < 256; v++) do_conv(v / 100, (v / 10) % 10, v % 10);

    // Random digit patterns, valid and invalid alike.
    for (int n = 0; n < 200; n++) begin
      h = $urandom_range(0, 3);
      t = $urandom_range(0, 15);
      u = $urandom_range(0, 15);
      do_conv(h, t, u);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
